alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage_pkg.sv | 22 ++
 rtl/alu_operand_stage_fwd_mux.sv | 42 ++++
 rtl/alu_operand_stage.sv | 118 +++++++++++
 tb/tb_alu_operand_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared types for the ALU operand stage: op codes, forward-select
// encoding and default widths.
package alu_operand_stage_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Operand bypass: MEM beats WB beats register-file data; x0 never bypassed.
module fwd_mux
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   reg_data,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   data
);

    fwd_sel_e sel;
    logic     rs_nz;

    assign rs_nz = (rs != '0);

    always_comb begin
        sel = FWD_REG;
        if (rs_nz && mem_reg_write && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (rs_nz && wb_reg_write && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        data = reg_data;
        unique case (sel)
            FWD_MEM: data = mem_result;
            FWD_WB:  data = wb_result;
            default: data = reg_data;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// One-entry operand register between decode and the ALU, with
// combinational MEM/WB bypass re-evaluated every cycle while held.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              alu_src,
    input  logic [2:0]        alu_control_in,
    input  logic              reg_write_in,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [XLEN-1:0]   wb_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   SrcA,
    output logic [XLEN-1:0]   SrcB,
    output logic [XLEN-1:0]   store_data,
    output logic [2:0]        ALUControl,
    output logic [REG_AW-1:0] rd_out,
    output logic              reg_write_out
);

    logic              valid_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [XLEN-1:0]   rs2_data_q;
    logic [XLEN-1:0]   imm_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [REG_AW-1:0] rd_q;
    logic              alu_src_q;
    logic [2:0]        op_q;
    logic              rw_q;
    logic [XLEN-1:0]   fwd_a;
    logic [XLEN-1:0]   fwd_b;
    logic              accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_src_q  <= 1'b0;
            op_q       <= '0;
            rw_q       <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q    <= 1'b1;
            rs1_data_q <= rs1_data;
            rs2_data_q <= rs2_data;
            imm_q      <= imm;
            rs1_q      <= rs1;
            rs2_q      <= rs2;
            rd_q       <= rd;
            alu_src_q  <= alu_src;
            op_q       <= alu_control_in;
            rw_q       <= reg_write_in;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs            (rs1_q),
        .reg_data      (rs1_data_q),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .data          (fwd_a)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs            (rs2_q),
        .reg_data      (rs2_data_q),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .data          (fwd_b)
    );

    assign out_valid     = valid_q;
    assign SrcA          = fwd_a;
    assign SrcB          = alu_src_q ? imm_q : fwd_b;
    assign store_data    = fwd_b;
    assign ALUControl    = op_q;
    assign rd_out        = rd_q;
    assign reg_write_out = rw_q && valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed vectors push expected
// operands, a negedge monitor pops and compares on each output transfer.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        alu_src;
    logic [2:0]  alu_control_in;
    logic        reg_write_in;
    logic        flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA, SrcB, store_data;
    logic [2:0]  ALUControl;
    logic [4:0]  rd_out;
    logic        reg_write_out;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .alu_src(alu_src), .alu_control_in(alu_control_in),
        .reg_write_in(reg_write_in), .flush(flush),
        .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_result(mem_result), .wb_result(wb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .store_data(store_data),
        .ALUControl(ALUControl), .rd_out(rd_out),
        .reg_write_out(reg_write_out)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got SrcA %h expected none",
                         SrcA);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_SrcA", SrcA, e.a);
                chk("sb_SrcB", SrcB, e.b);
                chk("sb_store_data", store_data, e.sd);
                chk("sb_ALUControl", 32'(ALUControl), 32'(e.op));
                chk("sb_rd_out", 32'(rd_out), 32'(e.rd));
                chk("sb_reg_write_out", 32'(reg_write_out), 32'(e.rw));
            end
        end
    end

    task automatic no_fwd();
        mem_rd = 5'd0; wb_rd = 5'd0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        mem_result = 32'h0; wb_result = 32'h0;
    endtask

    // Drives one instruction and returns one cycle after it is accepted.
    task automatic issue(
        input logic [31:0] r1d, input logic [31:0] r2d, input logic [31:0] im,
        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdi,
        input logic asrc, input logic [2:0] op, input logic rw,
        input bit push, input logic [31:0] ea, input logic [31:0] eb,
        input logic [31:0] esd);
        bit ok;
        exp_t e;
        rs1_data = r1d; rs2_data = r2d; imm = im;
        rs1 = r1; rs2 = r2; rd = rdi;
        alu_src = asrc; alu_control_in = op; reg_write_in = rw;
        in_valid = 1'b1;
        if (push) begin
            e.a = ea; e.b = eb; e.sd = esd; e.op = op; e.rd = rdi; e.rw = rw;
            q.push_back(e);
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got out_valid 1 expected 0");
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rs1_data = 32'h0; rs2_data = 32'h0; imm = 32'h0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        alu_src = 1'b0; alu_control_in = 3'd0; reg_write_in = 1'b0;
        no_fwd();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_SrcA", SrcA, 32'h0);
        chk("rst_SrcB", SrcB, 32'h0);
        chk("rst_store_data", store_data, 32'h0);
        chk("rst_ALUControl", 32'(ALUControl), 32'd0);
        chk("rst_rd_out", 32'(rd_out), 32'd0);
        chk("rst_reg_write_out", 32'(reg_write_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Plain operands, no bypass
        issue(32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd4, 1'b0, 3'(ALU_ADD), 1'b1,
              1'b1, 32'd5, 32'd7, 32'd7);
        chk("lat1_out_valid", 32'(out_valid), 32'd1);
        wait_idle();

        // MEM beats WB on rs1
        mem_rd = 5'd3; mem_reg_write = 1'b1; mem_result = 32'hAA;
        wb_rd = 5'd3; wb_reg_write = 1'b1; wb_result = 32'hBB;
        issue(32'h11, 32'h77, 32'h0, 5'd3, 5'd5, 5'd9, 1'b0, 3'(ALU_SUB), 1'b1,
              1'b1, 32'hAA, 32'h77, 32'h77);
        wait_idle();

        // Bypass re-evaluated while stalled: MEM drops, WB takes over
        out_ready = 1'b0;
        issue(32'h11, 32'h77, 32'h0, 5'd3, 5'd5, 5'd9, 1'b0, 3'(ALU_SUB), 1'b1,
              1'b1, 32'hBB, 32'h77, 32'h77);
        @(negedge clk);
        chk("stall_SrcA_mem", SrcA, 32'hAA);
        @(posedge clk); #1;
        mem_reg_write = 1'b0;
        @(negedge clk);
        chk("stall_SrcA_wb", SrcA, 32'hBB);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();

        // x0 is never bypassed
        no_fwd();
        mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hFF;
        wb_rd = 5'd0; wb_reg_write = 1'b1; wb_result = 32'hEE;
        issue(32'h12, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 3'(ALU_AND), 1'b0,
              1'b1, 32'h12, 32'h0, 32'h0);
        wait_idle();

        // Immediate SrcB; store_data still bypassed rs2
        no_fwd();
        mem_rd = 5'd6; mem_reg_write = 1'b1; mem_result = 32'h10;
        issue(32'h1, 32'h99, 32'hFFFFFFFC, 5'd2, 5'd6, 5'd7, 1'b1,
              3'(ALU_SLT), 1'b1, 1'b1, 32'h1, 32'hFFFFFFFC, 32'h10);
        wait_idle();

        // Different sources per operand: WB on rs1, MEM on rs2
        no_fwd();
        wb_rd = 5'd7; wb_reg_write = 1'b1; wb_result = 32'h1234;
        mem_rd = 5'd8; mem_reg_write = 1'b1; mem_result = 32'h5678;
        issue(32'h3, 32'h4, 32'h0, 5'd7, 5'd8, 5'd10, 1'b0, 3'(ALU_OR), 1'b1,
              1'b1, 32'h1234, 32'h5678, 32'h5678);
        wait_idle();

        // Backpressure: 3 stalled cycles with a second instruction waiting
        no_fwd();
        out_ready = 1'b0;
        issue(32'hA1, 32'hA2, 32'h0, 5'd11, 5'd12, 5'd13, 1'b0, 3'(ALU_ADD),
              1'b1, 1'b1, 32'hA1, 32'hA2, 32'hA2);
        rs1_data = 32'hB1; rs2_data = 32'hB2; imm = 32'hB3;
        rs1 = 5'd14; rs2 = 5'd15; rd = 5'd16;
        alu_src = 1'b1; alu_control_in = 3'(ALU_SUB); reg_write_in = 1'b0;
        in_valid = 1'b1;
        begin
            exp_t e;
            e.a = 32'hB1; e.b = 32'hB3; e.sd = 32'hB2;
            e.op = 3'(ALU_SUB); e.rd = 5'd16; e.rw = 1'b0;
            q.push_back(e);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_SrcA_hold", SrcA, 32'hA1);
            chk("stall_rd_hold", 32'(rd_out), 32'd13);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("next_out_valid", 32'(out_valid), 32'd1);
        wait_idle();

        // Flush beats a simultaneous accept
        in_valid = 1'b1; flush = 1'b1; reg_write_in = 1'b1; rd = 5'd20;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_acc_out_valid", 32'(out_valid), 32'd0);
        chk("flush_acc_reg_write", 32'(reg_write_out), 32'd0);

        // Flush kills a held instruction
        out_ready = 1'b0;
        issue(32'hC1, 32'hC2, 32'h0, 5'd1, 5'd2, 5'd21, 1'b0, 3'(ALU_ADD),
              1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("held_reg_write", 32'(reg_write_out), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_held_out_valid", 32'(out_valid), 32'd0);
        chk("flush_held_reg_write", 32'(reg_write_out), 32'd0);

        // Reset mid-stall with a pending input
        issue(32'hD1, 32'hD2, 32'hD3, 5'd4, 5'd5, 5'd22, 1'b1, 3'(ALU_SLT),
              1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hFF;
        reset = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_SrcA", SrcA, 32'h0);
        chk("rst2_SrcB", SrcB, 32'h0);
        chk("rst2_store_data", store_data, 32'h0);
        chk("rst2_ALUControl", 32'(ALUControl), 32'd0);
        chk("rst2_rd_out", 32'(rd_out), 32'd0);
        chk("rst2_reg_write_out", 32'(reg_write_out), 32'd0);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
